// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin front end sharing one FP unit between two requesters.
// Illegal opcodes and unit timeouts answer with a quiet NaN and rsp_err set.
module fpu_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [65:0] req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [65:0] req1_cmd,
    output logic        req1_ready,
    output logic        fpu_start,
    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0]  OP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        gnt1;
    logic        accept;
    logic [65:0] cmd_sel;

    // Ready is gated by reset so nothing is taken while reset is held low.
    always_comb begin
        gnt1 = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt1 = ~last_grant_q;
        end
        accept     = reset && (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !gnt1;
        req1_ready = accept && gnt1;
        cmd_sel    = gnt1 ? req1_cmd : req0_cmd;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = gnt1;
                    id_d         = gnt1;
                    if (cmd_sel[1:0] == OP_ILL) begin
                        state_d    = RESP;
                        rsp_id_d   = gnt1;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = QNAN;
                    end else begin
                        state_d = ISSUE;
                        op_d    = cmd_sel[1:0];
                        a_d     = cmd_sel[33:2];
                        b_d     = cmd_sel[65:34];
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
            WAIT: begin
                // A completion on the final count still returns the result.
                if (fpu_done) begin
                    state_d    = RESP;
                    rsp_id_d   = id_q;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = fpu_result;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = RESP;
                    rsp_id_d   = id_q;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = QNAN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            id_q         <= 1'b0;
            op_q         <= 2'b00;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign fpu_start = (state_q == ISSUE);
    assign fpu_op    = op_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: scoreboard bench for fpu_arbiter with a delayed-completion FP model.
// Responses are queued by a monitor and matched against expectations pushed at drive time.
module tb_fpu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0;
    logic [65:0] req0_cmd = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [65:0] req1_cmd = '0;
    logic        req1_ready;
    logic        fpu_start;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    fpu_arbiter #(.TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_cmd   (req0_cmd),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_cmd   (req1_cmd),
        .req1_ready (req1_ready),
        .fpu_start  (fpu_start),
        .fpu_op     (fpu_op),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_done   (fpu_done),
        .fpu_result (fpu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    int          got_cyc_q[$];
    logic [65:0] start_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int starts = 0;
    int rsps = 0;
    int both_rdy = 0;

    bit          model_en = 1'b1;
    int          model_dly = 3;
    logic [31:0] model_res = 32'h4100_0000;
    int          kick_req = 0;
    int          kick_ack = 0;
    int          cd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus FP unit model; all DUT inputs change on the falling edge.
    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_rdy++;
        if (rsp_valid) begin
            got_q.push_back('{rsp_id, rsp_err, rsp_data});
            got_cyc_q.push_back(cyc);
            rsps++;
        end
        if (fpu_start) begin
            start_q.push_back({fpu_b, fpu_a, fpu_op});
            starts++;
        end
        fpu_done = 1'b0;
        if (!reset) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                fpu_done   = 1'b1;
                fpu_result = model_res;
            end
        end
        if (reset && fpu_start && model_en) cd = model_dly;
        if (kick_req != kick_ack) begin
            kick_ack   = kick_req;
            fpu_done   = 1'b1;
            fpu_result = 32'hDEAD_BEEF;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic send(input bit id, input logic [65:0] cmd,
                        output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1;
            req1_cmd   = cmd;
        end else begin
            req0_valid = 1'b1;
            req0_cmd   = cmd;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic drive_both(input int n, input bit hold,
                              output logic [3:0] gv, output int cnt);
        logic g;
        gv  = '0;
        cnt = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 400 && cnt < n; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                g       = req1_ready;
                gv[cnt] = g;
                cnt++;
                if (!hold) begin
                    @(posedge clk); #1;
                    if (g) req1_valid = 1'b0;
                    else req0_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic take_rsp(input int lim, output bit ok,
                            output rsp_t e, output rsp_t g, output int gc);
        ok = 1'b0;
        e  = '0;
        g  = '0;
        gc = 0;
        for (int i = 0; i < lim; i++) begin
            if (got_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (ok) begin
            g  = got_q.pop_front();
            gc = got_cyc_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req0_ready, req1_ready, fpu_start, fpu_op, fpu_a, fpu_b,
             rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b rsp_valid=%b rsp_data=%h, required all zero",
                     busy, rsp_valid, rsp_data);
        end
        req0_valid = 1'b1;
        req0_cmd   = {32'h4040_0000, 32'h40A0_0000, 2'b00};
        @(negedge clk); #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: req0_ready=%b, required 0", req0_ready);
        end
        req0_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int acc, gc, s0;
        rsp_t e, g;
        logic [65:0] cmd;
        logic [65:0] st;
        cmd = {32'h4040_0000, 32'h40A0_0000, 2'b00};
        start_q.delete();
        s0 = starts;
        model_res = 32'h4100_0000;
        exp_q.push_back('{1'b0, 1'b0, 32'h4100_0000});
        send(1'b0, cmd, acc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_accept: no ready, required acceptance");
        end
        take_rsp(50, ok, e, g, gc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_rsp: no response, required one");
        end else begin
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL basic_data: got id=%0d err=%0d data=%h, required id=%0d err=%0d data=%h",
                         g.id, g.err, g.data, e.id, e.err, e.data);
            end
            checks++;
            if (gc - acc !== 5) begin
                failures++;
                $display("FAIL basic_latency: got %0d, required 5", gc - acc);
            end
        end
        checks++;
        if (starts - s0 !== 1) begin
            failures++;
            $display("FAIL basic_starts: got %0d, required 1", starts - s0);
        end
        st = (start_q.size() > 0) ? start_q.pop_front() : '0;
        checks++;
        if (st !== cmd) begin
            failures++;
            $display("FAIL basic_issue: got %h, required %h", st, cmd);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_tie();
        bit ok;
        int gc, cnt, b0;
        rsp_t e, g;
        logic [3:0] gv;
        apply_reset();
        b0 = both_rdy;
        model_res = 32'h4100_0000;
        req0_cmd = {32'h4040_0000, 32'h40A0_0000, 2'b00};
        req1_cmd = {32'h4080_0000, 32'h4000_0000, 2'b10};
        exp_q.push_back('{1'b0, 1'b0, 32'h4100_0000});
        exp_q.push_back('{1'b1, 1'b0, 32'h4100_0000});
        drive_both(2, 1'b0, gv, cnt);
        checks++;
        if (cnt !== 2 || gv[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL tie_order: got cnt=%0d grants=%b, required cnt=2 grants=10",
                     cnt, gv[1:0]);
        end
        for (int k = 0; k < 2; k++) begin
            take_rsp(50, ok, e, g, gc);
            checks++;
            if (!ok || g !== e) begin
                failures++;
                $display("FAIL tie_rsp%0d: got ok=%0d id=%0d data=%h, required id=%0d data=%h",
                         k, ok, g.id, g.data, e.id, e.data);
            end
        end
        checks++;
        if (both_rdy - b0 !== 0) begin
            failures++;
            $display("FAIL tie_both_ready: got %0d, required 0", both_rdy - b0);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        int acc, gc, s0;
        rsp_t e, g;
        s0 = starts;
        exp_q.push_back('{1'b1, 1'b1, QNAN});
        send(1'b1, {32'h1234_5678, 32'h9ABC_DEF0, 2'b11}, acc, ok);
        take_rsp(20, ok, e, g, gc);
        checks++;
        if (!ok || g !== e) begin
            failures++;
            $display("FAIL illegal_rsp: got ok=%0d id=%0d err=%0d data=%h, required id=%0d err=%0d data=%h",
                     ok, g.id, g.err, g.data, e.id, e.err, e.data);
        end
        checks++;
        if (gc - acc !== 1) begin
            failures++;
            $display("FAIL illegal_latency: got %0d, required 1", gc - acc);
        end
        checks++;
        if (starts - s0 !== 0) begin
            failures++;
            $display("FAIL illegal_start: got %0d, required 0", starts - s0);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b1, 1'b1, QNAN}) begin
            failures++;
            $display("FAIL rsp_hold: got valid=%b id=%b err=%b data=%h, required 0 1 1 %h",
                     rsp_valid, rsp_id, rsp_err, rsp_data, QNAN);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int acc, gc, r0;
        rsp_t e, g;
        logic [65:0] cmd;
        logic [65:0] st;
        cmd = {32'h4040_0000, 32'h4100_0000, 2'b01};
        model_en = 1'b0;
        start_q.delete();
        exp_q.push_back('{1'b0, 1'b1, QNAN});
        send(1'b0, cmd, acc, ok);
        take_rsp(200, ok, e, g, gc);
        checks++;
        if (!ok || g !== e) begin
            failures++;
            $display("FAIL timeout_rsp: got ok=%0d err=%0d data=%h, required err=1 data=%h",
                     ok, g.err, g.data, e.data);
        end
        checks++;
        if (gc - acc !== 66) begin
            failures++;
            $display("FAIL timeout_latency: got %0d, required 66", gc - acc);
        end
        st = (start_q.size() > 0) ? start_q.pop_front() : '0;
        checks++;
        if (st !== cmd) begin
            failures++;
            $display("FAIL timeout_issue: got %h, required %h", st, cmd);
        end
        r0 = rsps;
        kick_req++;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rsps - r0 !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_late_done: got rsps=%0d busy=%b, required 0 0",
                     rsps - r0, busy);
        end
        model_en = 1'b1;
    endtask

    task automatic test_reset_wait();
        bit ok;
        int acc, gc, r0;
        rsp_t e, g;
        model_en = 1'b0;
        send(1'b0, {32'h4040_0000, 32'h40A0_0000, 2'b00}, acc, ok);
        repeat (5) @(posedge clk);
        #3;
        r0 = rsps;
        reset = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, fpu_start, fpu_op, fpu_a, fpu_b,
             rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b fpu_a=%h rsp_data=%h, required all zero",
                     busy, fpu_a, rsp_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
        kick_req++;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (rsps - r0 !== 0 || busy !== 1'b0 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL abort_quiet: got rsps=%0d busy=%b data=%h, required 0 0 0",
                     rsps - r0, busy, rsp_data);
        end
        model_en = 1'b1;
        model_res = 32'h4000_0000;
        exp_q.push_back('{1'b1, 1'b0, 32'h4000_0000});
        send(1'b1, {32'h3F80_0000, 32'h3F80_0000, 2'b00}, acc, ok);
        take_rsp(50, ok, e, g, gc);
        checks++;
        if (!ok || g !== e) begin
            failures++;
            $display("FAIL abort_next: got ok=%0d id=%0d data=%h, required id=%0d data=%h",
                     ok, g.id, g.data, e.id, e.data);
        end
    endtask

    task automatic test_alternate();
        bit ok;
        int gc, cnt;
        rsp_t e, g;
        logic [3:0] gv;
        apply_reset();
        model_res = 32'h4100_0000;
        req0_cmd = {32'h4040_0000, 32'h40A0_0000, 2'b00};
        req1_cmd = {32'h4080_0000, 32'h4000_0000, 2'b10};
        for (int k = 0; k < 4; k++) exp_q.push_back('{k[0], 1'b0, 32'h4100_0000});
        drive_both(4, 1'b1, gv, cnt);
        checks++;
        if (cnt !== 4 || gv !== 4'b1010) begin
            failures++;
            $display("FAIL alt_grants: got cnt=%0d grants=%b, required cnt=4 grants=1010",
                     cnt, gv);
        end
        for (int k = 0; k < 4; k++) begin
            take_rsp(50, ok, e, g, gc);
            checks++;
            if (!ok || g !== e) begin
                failures++;
                $display("FAIL alt_rsp%0d: got ok=%0d id=%0d data=%h, required id=%0d data=%h",
                         k, ok, g.id, g.data, e.id, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_illegal();
        test_timeout();
        test_reset_wait();
        test_alternate();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
